// File: rtl/sr_latch_driver_if.sv
// sr_latch_driver_if: request handshake, latch drive lines and status of the SR latch driver.
interface sr_latch_driver_if;
    logic       req_valid;
    logic [1:0] req_op;
    logic       req_ready;
    logic       s;
    logic       r;
    logic       enable;
    logic       q_fb;
    logic       busy;
    logic       done;
    logic       err;
    logic       q_model;
    logic [7:0] cmd_count;
    modport master (
        output req_valid, req_op, q_fb,
        input  req_ready, s, r, enable, busy, done, err, q_model, cmd_count
    );
    modport slave (
        input  req_valid, req_op, q_fb,
        output req_ready, s, r, enable, busy, done, err, q_model, cmd_count
    );
endinterface

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns set/reset/toggle/nop requests into legal S/R/enable pulses and checks latch feedback.
module sr_latch_driver #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input logic              clk,
    input logic              rst,
    sr_latch_driver_if.slave bus
);
    typedef enum logic [2:0] {INIT, IDLE, SETUP, PULSE, HOLD, CHECK, GAP} state_t;
    state_t     r_state;
    logic       r_s;
    logic       r_r;
    logic       r_en;
    logic       r_done;
    logic       r_err;
    logic       r_q;
    logic       r_init;
    logic [3:0] r_tmr;
    logic [7:0] r_cnt;
    logic       w_set;
    assign w_set         = bus.req_op == 2'b10 || (bus.req_op == 2'b11 && !r_q);
    assign bus.req_ready = r_state == IDLE;
    assign bus.busy      = r_state != IDLE;
    assign bus.s         = r_s;
    assign bus.r         = r_r;
    assign bus.enable    = r_en;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.q_model   = r_q;
    assign bus.cmd_count = r_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_q     <= 1'b0;
            r_init  <= 1'b1;
            r_tmr   <= 4'd0;
            r_cnt   <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                INIT: begin
                    r_state <= SETUP;
                    r_r     <= 1'b1;
                end
                IDLE: if (bus.req_valid) begin
                    if (bus.req_op == 2'b00) begin
                        r_state <= CHECK;
                        r_done  <= 1'b1;
                        r_cnt   <= r_cnt + 8'd1;
                    end else begin
                        r_state <= SETUP;
                        r_s     <= w_set;
                        r_r     <= !w_set;
                        r_q     <= w_set;
                    end
                end
                SETUP: begin
                    r_state <= PULSE;
                    r_en    <= 1'b1;
                    r_tmr   <= 4'(PULSE_CYCLES - 1);
                end
                PULSE: if (r_tmr == 4'd0) begin
                    r_state <= HOLD;
                    r_en    <= 1'b0;
                end else begin
                    r_tmr <= r_tmr - 4'd1;
                end
                HOLD: begin
                    r_state <= CHECK;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    // the power-up initialisation is not a user request
                    if (!r_init) begin
                        r_done <= 1'b1;
                        r_cnt  <= r_cnt + 8'd1;
                    end
                end
                CHECK: begin
                    if (bus.q_fb != r_q) r_err <= 1'b1;
                    r_init  <= 1'b0;
                    r_state <= GAP_CYCLES > 0 ? GAP : IDLE;
                    r_tmr   <= 4'(GAP_CYCLES - 1);
                end
                GAP: if (r_tmr == 4'd0) r_state <= IDLE;
                     else r_tmr <= r_tmr - 4'd1;
                default: r_state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: random and directed requests against a latch model and a request-level reference model.
module tb_sr_latch_driver;
    localparam int P = 2;
    localparam int G = 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lq = 1'b1;
    logic force0 = 1'b0;
    int   errs = 0;
    int   checks = 0;
    logic exp_q = 1'b0;
    logic exp_err = 1'b0;
    int   exp_cnt = 0;
    sr_latch_driver_if ifc ();
    sr_latch_driver #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (.clk(clk), .rst(rst), .bus(ifc));
    always #5 clk = ~clk;
    always @(posedge clk) if (ifc.enable) lq <= ifc.s ? 1'b1 : ifc.r ? 1'b0 : lq;
    assign ifc.q_fb = force0 ? 1'b0 : lq;
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic release_check();
        rst = 1'b0;
        tick();
        for (int k = 0; k <= P + G + 3; k++) begin
            chk("init_r", ifc.r, k <= P + 1);
            chk("init_s", ifc.s, 0);
            chk("init_en", ifc.enable, k >= 1 && k <= P);
            chk("init_rdy", ifc.req_ready, k == P + G + 3);
            chk("init_done", ifc.done, 0);
            if (k < P + G + 3) tick();
        end
        chk("init_qm", ifc.q_model, 0);
        chk("init_err", ifc.err, 0);
        chk("init_cnt", ifc.cmd_count, 0);
        chk("init_fb", ifc.q_fb, 0);
        exp_q = 1'b0;
        exp_err = 1'b0;
        exp_cnt = 0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        ifc.req_valid = 1'b0;
        tick();
        tick();
        chk("rst_s", ifc.s, 0);
        chk("rst_r", ifc.r, 0);
        chk("rst_en", ifc.enable, 0);
        chk("rst_rdy", ifc.req_ready, 0);
        chk("rst_busy", ifc.busy, 1);
        chk("rst_done", ifc.done, 0);
        chk("rst_err", ifc.err, 0);
        chk("rst_qm", ifc.q_model, 0);
        chk("rst_cnt", ifc.cmd_count, 0);
        release_check();
    endtask
    task automatic wait_ready();
        for (int i = 0; i < 40 && !ifc.req_ready; i++) tick();
        chk("ready_timeout", ifc.req_ready, 1);
    endtask
    task automatic issue(input logic [1:0] op);
        logic drv;
        logic ns;
        logic seen;
        wait_ready();
        drv = op != 2'b00;
        ns = op == 2'b10 ? 1'b1 : op == 2'b01 ? 1'b0 : !exp_q;
        ifc.req_valid = 1'b1;
        ifc.req_op = op;
        tick();
        ifc.req_valid = 1'b0;
        if (drv) exp_q = ns;
        seen = 1'b0;
        for (int n = 1; n <= 12 && !seen; n++) begin
            chk("cmd_en", ifc.enable, drv && n >= 2 && n <= P + 1);
            chk("cmd_s", ifc.s, drv && ns && n <= P + 2);
            chk("cmd_r", ifc.r, drv && !ns && n <= P + 2);
            chk("cmd_done", ifc.done, n == (drv ? P + 3 : 1));
            if (ifc.done) begin
                seen = 1'b1;
                exp_cnt = (exp_cnt + 1) % 256;
                exp_err = exp_err | (force0 && exp_q);
                chk("cmd_cnt", ifc.cmd_count, exp_cnt);
                chk("cmd_qm", ifc.q_model, exp_q);
            end
            tick();
        end
        chk("cmd_done_seen", seen, 1);
        chk("cmd_err", ifc.err, exp_err);
    endtask
    initial begin
        int acc;
        int last;
        int cyc;
        logic lastdrv;
        logic [1:0] op;
        ifc.req_valid = 1'b0;
        ifc.req_op = 2'b00;
        do_reset();
        issue(2'b10);
        chk("set_fb", ifc.q_fb, 1);
        issue(2'b11);
        chk("tog1_qm", ifc.q_model, 0);
        issue(2'b00);
        chk("nop_qm", ifc.q_model, 0);
        issue(2'b11);
        chk("tog2_qm", ifc.q_model, 1);
        chk("tog_cnt", ifc.cmd_count, 4);
        wait_ready();
        ifc.req_valid = 1'b1;
        ifc.req_op = 2'b01;
        tick();
        ifc.req_valid = 1'b0;
        tick();
        tick();
        chk("abort_pulse_en", ifc.enable, 1);
        rst = 1'b1;
        tick();
        chk("abort_en", ifc.enable, 0);
        chk("abort_s", ifc.s, 0);
        chk("abort_r", ifc.r, 0);
        chk("abort_qm", ifc.q_model, 0);
        chk("abort_cnt", ifc.cmd_count, 0);
        chk("abort_done", ifc.done, 0);
        release_check();
        force0 = 1'b1;
        issue(2'b10);
        chk("err_set", ifc.err, 1);
        for (int i = 0; i < 3; i++) issue(2'b01);
        chk("err_sticky", ifc.err, 1);
        force0 = 1'b0;
        do_reset();
        acc = 0;
        last = -1;
        cyc = 0;
        lastdrv = 1'b0;
        ifc.req_valid = 1'b1;
        while (acc < 300 && cyc < 5000) begin
            op = 2'($urandom_range(0, 3));
            ifc.req_op = op;
            chk("rnd_s_and_r", ifc.s && ifc.r, 0);
            chk("rnd_en", ifc.enable, last >= 0 && lastdrv && cyc - last >= 2 && cyc - last <= P + 1);
            chk("rnd_busy", ifc.busy, !ifc.req_ready);
            if (ifc.req_ready) begin
                if (last >= 0) chk("rnd_spacing", cyc - last, lastdrv ? P + G + 4 : G + 2);
                last = cyc;
                lastdrv = op != 2'b00;
                exp_q = op == 2'b10 ? 1'b1 : op == 2'b01 ? 1'b0 : op == 2'b11 ? !exp_q : exp_q;
                acc++;
            end
            tick();
            cyc++;
        end
        ifc.req_valid = 1'b0;
        chk("rnd_accepts", acc, 300);
        for (int i = 0; i < 12; i++) tick();
        chk("rnd_wrap_cnt", ifc.cmd_count, 300 % 256);
        chk("rnd_qm", ifc.q_model, exp_q);
        chk("rnd_err", ifc.err, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
